// File: rtl/ddr4_rx_lane_bitslip_align.sv
// ddr4_rx_lane_bitslip_align
//   Receive-side word aligner for one DDR4 DQ lane (FAB_CLK domain).
//   During read training it compares deserialised words against
//   TRAIN_PATTERN and pulses RX_BIT_SLIP into the IOD until the word
//   boundary lines up. Once locked it forwards read words with a
//   one-cycle registered latency.
//
// Ports
//   FAB_CLK      in   fabric clock, rising edge
//   ARST         in   asynchronous active-high reset
//   TRAIN_START  in   single-cycle start/restart pulse
//   RX_DATA_IN   in   [7:0] deserialised word, bit 0 first in time
//   RX_VALID_IN  in   RX_DATA_IN carries read data this cycle
//   RX_BIT_SLIP  out  single-cycle slip pulse to the IOD
//   RX_DATA_OUT  out  [7:0] aligned read word (registered)
//   RX_VALID_OUT out  RX_DATA_OUT valid (LOCKED only)
//   TRAIN_DONE   out  lock achieved, held until start/reset
//   TRAIN_FAIL   out  all 8 alignments exhausted, held until start/reset
//   SLIP_COUNT   out  [2:0] slips issued since the last start
module ddr4_rx_lane_bitslip_align #(
  parameter logic [7:0]  TRAIN_PATTERN = 8'h1D,
  parameter int unsigned MATCH_COUNT   = 16,
  parameter int unsigned SLIP_SETTLE   = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       TRAIN_START,
  input  logic [7:0] RX_DATA_IN,
  input  logic       RX_VALID_IN,
  output logic       RX_BIT_SLIP,
  output logic [7:0] RX_DATA_OUT,
  output logic       RX_VALID_OUT,
  output logic       TRAIN_DONE,
  output logic       TRAIN_FAIL,
  output logic [2:0] SLIP_COUNT
);

  localparam logic [7:0] LP_MATCH  = 8'(MATCH_COUNT);
  localparam logic [3:0] LP_SETTLE = 4'(SLIP_SETTLE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t     r_state;
  logic [7:0] r_match;
  logic [3:0] r_settle;
  logic       r_slip;
  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic       r_done;
  logic       r_fail;
  logic [2:0] r_slip_cnt;

  logic       w_match;
  logic [7:0] w_match_next;

  assign w_match      = (RX_DATA_IN == TRAIN_PATTERN);
  // Saturating increment; lock fires at LP_MATCH so the ceiling is never hit
  // in legal configurations, but the counter must not wrap regardless.
  assign w_match_next = (r_match == 8'hFF) ? r_match : r_match + 8'd1;

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_state     <= ST_IDLE;
      r_match     <= '0;
      r_settle    <= '0;
      r_slip      <= 1'b0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_slip_cnt  <= '0;
    end else begin
      // Slip and valid are single-state qualifiers; default them low.
      r_slip      <= 1'b0;
      r_valid_out <= 1'b0;
      if (TRAIN_START) begin
        // Restart from any state. A slip pulse already on the wire this
        // cycle still completes; only the count is cleared.
        r_state    <= ST_COMPARE;
        r_match    <= '0;
        r_settle   <= '0;
        r_slip_cnt <= '0;
        r_done     <= 1'b0;
        r_fail     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_COMPARE: begin
            if (RX_VALID_IN) begin
              if (w_match) begin
                r_match <= w_match_next;
                if (w_match_next == LP_MATCH) begin
                  r_state <= ST_LOCKED;
                  r_done  <= 1'b1;
                end
              end else begin
                r_match <= '0;
                if (r_slip_cnt == 3'd7) begin
                  r_state <= ST_FAIL;
                  r_fail  <= 1'b1;
                end else begin
                  r_state <= ST_SLIP;
                  r_slip  <= 1'b1;
                end
              end
            end
          end
          ST_SLIP: begin
            r_slip_cnt <= r_slip_cnt + 3'd1;
            r_settle   <= LP_SETTLE;
            r_state    <= ST_SETTLE;
          end
          ST_SETTLE: begin
            // Leaving on the 1->0 step keeps SETTLE exactly SLIP_SETTLE
            // cycles long.
            if (r_settle <= 4'd1) begin
              r_settle <= '0;
              r_state  <= ST_COMPARE;
            end else begin
              r_settle <= r_settle - 4'd1;
            end
          end
          ST_LOCKED: begin
            r_data_out  <= RX_DATA_IN;
            r_valid_out <= RX_VALID_IN;
          end
          ST_FAIL: begin
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign RX_BIT_SLIP  = r_slip;
  assign RX_DATA_OUT  = r_data_out;
  assign RX_VALID_OUT = r_valid_out;
  assign TRAIN_DONE   = r_done;
  assign TRAIN_FAIL   = r_fail;
  assign SLIP_COUNT   = r_slip_cnt;

endmodule

// File: tb/tb_ddr4_rx_lane_bitslip_align.sv
// Directed bench for ddr4_rx_lane_bitslip_align with a simple IOD model
// that rotates the incoming word left by one bit per slip pulse.
module tb_ddr4_rx_lane_bitslip_align;

  logic       FAB_CLK;
  logic       ARST;
  logic       TRAIN_START;
  logic [7:0] RX_DATA_IN;
  logic       RX_VALID_IN;
  logic       RX_BIT_SLIP;
  logic [7:0] RX_DATA_OUT;
  logic       RX_VALID_OUT;
  logic       TRAIN_DONE;
  logic       TRAIN_FAIL;
  logic [2:0] SLIP_COUNT;

  ddr4_rx_lane_bitslip_align #(
    .TRAIN_PATTERN (8'h1D),
    .MATCH_COUNT   (16),
    .SLIP_SETTLE   (4)
  ) dut (
    .FAB_CLK      (FAB_CLK),
    .ARST         (ARST),
    .TRAIN_START  (TRAIN_START),
    .RX_DATA_IN   (RX_DATA_IN),
    .RX_VALID_IN  (RX_VALID_IN),
    .RX_BIT_SLIP  (RX_BIT_SLIP),
    .RX_DATA_OUT  (RX_DATA_OUT),
    .RX_VALID_OUT (RX_VALID_OUT),
    .TRAIN_DONE   (TRAIN_DONE),
    .TRAIN_FAIL   (TRAIN_FAIL),
    .SLIP_COUNT   (SLIP_COUNT)
  );

  initial begin
    FAB_CLK = 1'b0;
    forever #5 FAB_CLK = ~FAB_CLK;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int slip_q[$];

  // Stimulus modes
  logic        iod_en   = 1'b0;
  logic [7:0]  iod_base = 8'h1D;
  int unsigned iod_rot  = 0;
  logic        gap_en   = 1'b0;
  int          corrupt_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rol8(input logic [7:0] v, input int unsigned n);
    logic [7:0] r;
    r = v;
    for (int unsigned i = 0; i < n % 8; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic drive();
    if (iod_en) begin
      RX_DATA_IN  = rol8(iod_base, iod_rot);
      RX_VALID_IN = 1'b1;
    end else if (gap_en) begin
      RX_VALID_IN = (cyc % 2 == 0);
      if (cyc == corrupt_cyc) RX_DATA_IN = 8'h00;
      else                    RX_DATA_IN = RX_VALID_IN ? 8'h1D : 8'hFF;
    end
  endtask

  // Advance one cycle; sample 1 ns after the edge, log slips, update IOD.
  task automatic tick();
    @(posedge FAB_CLK);
    #1;
    cyc++;
    if (RX_BIT_SLIP) begin
      slip_q.push_back(cyc);
      iod_rot++;
    end
    drive();
  endtask

  // Start pulse occupies cycle 0; returns at cycle 1.
  task automatic start_train();
    slip_q.delete();
    iod_rot = 0;
    cyc = 0;
    drive();
    TRAIN_START = 1'b1;
    tick();
    TRAIN_START = 1'b0;
  endtask

  task automatic wait_flag(input int budget, output int at);
    while (!(TRAIN_DONE || TRAIN_FAIL) && cyc < budget) tick();
    at = cyc;
  endtask

  int at;

  initial begin
    ARST        = 1'b1;
    TRAIN_START = 1'b0;
    RX_DATA_IN  = 8'h00;
    RX_VALID_IN = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_slip",  RX_BIT_SLIP,  0);
    chk("rst_data",  RX_DATA_OUT,  8'h00);
    chk("rst_valid", RX_VALID_OUT, 0);
    chk("rst_done",  TRAIN_DONE,   0);
    chk("rst_fail",  TRAIN_FAIL,   0);
    chk("rst_cnt",   SLIP_COUNT,   0);
    ARST = 1'b0;
    repeat (3) tick();
    chk("idle_done", TRAIN_DONE, 0);

    // Aligned pattern: done 17 cycles after start, no slips
    iod_en = 1'b1; iod_base = 8'h1D;
    start_train();
    wait_flag(100, at);
    chk("align_done_cyc", at, 17);
    chk("align_cnt", SLIP_COUNT, 0);
    chk("align_slips", slip_q.size(), 0);
    chk("align_fail", TRAIN_FAIL, 0);

    // Locked passthrough
    iod_en = 1'b0;
    RX_DATA_IN = 8'hA7; RX_VALID_IN = 1'b1;
    tick();
    chk("pt_data_a7", RX_DATA_OUT, 8'hA7);
    chk("pt_valid_1", RX_VALID_OUT, 1);
    RX_DATA_IN = 8'h3C; RX_VALID_IN = 1'b0;
    tick();
    chk("pt_valid_0", RX_VALID_OUT, 0);
    chk("pt_data_3c", RX_DATA_OUT, 8'h3C);

    // Restart from LOCKED
    iod_en = 1'b1; iod_base = 8'h1D;
    start_train();
    chk("restart_done_drop", TRAIN_DONE, 0);
    chk("restart_valid_drop", RX_VALID_OUT, 0);
    wait_flag(100, at);
    chk("restart_done_cyc", at, 17);

    // Misaligned by 3: A3 -> 47 -> 8E -> 1D
    iod_base = 8'hA3;
    start_train();
    wait_flag(200, at);
    chk("mis_done_cyc", at, 35);
    chk("mis_done", TRAIN_DONE, 1);
    chk("mis_cnt", SLIP_COUNT, 3);
    chk("mis_slips", slip_q.size(), 3);
    if (slip_q.size() == 3) begin
      chk("mis_first_slip", slip_q[0], 2);
      chk("mis_space_1", slip_q[1] - slip_q[0], 6);
      chk("mis_space_2", slip_q[2] - slip_q[1], 6);
    end

    // Unalignable
    iod_base = 8'h00;
    start_train();
    wait_flag(300, at);
    chk("ua_fail_cyc", at, 44);
    chk("ua_fail", TRAIN_FAIL, 1);
    chk("ua_done", TRAIN_DONE, 0);
    chk("ua_cnt", SLIP_COUNT, 7);
    chk("ua_slips", slip_q.size(), 7);
    chk("ua_valid", RX_VALID_OUT, 0);

    // Gapped valid, garbage on invalid cycles
    iod_en = 1'b0; gap_en = 1'b1; corrupt_cyc = -1;
    start_train();
    wait_flag(200, at);
    chk("gap_done_cyc", at, 33);
    chk("gap_slips", slip_q.size(), 0);
    chk("gap_cnt", SLIP_COUNT, 0);

    // Gapped valid with the 15th valid word corrupted
    corrupt_cyc = 30;
    start_train();
    wait_flag(300, at);
    chk("gc_done_cyc", at, 67);
    chk("gc_slips", slip_q.size(), 1);
    if (slip_q.size() == 1) chk("gc_slip_cyc", slip_q[0], 31);
    chk("gc_cnt", SLIP_COUNT, 1);
    gap_en = 1'b0; corrupt_cyc = -1;

    // Reset during a slip pulse drops it asynchronously
    iod_en = 1'b1; iod_base = 8'hA3;
    start_train();
    while (!RX_BIT_SLIP && cyc < 20) tick();
    chk("rs_slip_pre", RX_BIT_SLIP, 1);
    ARST = 1'b1;
    #1;
    chk("rs_slip_drop", RX_BIT_SLIP, 0);
    tick();
    ARST = 1'b0;

    // Reset during SETTLE, then FSM waits in IDLE
    start_train();
    while (!RX_BIT_SLIP && cyc < 20) tick();
    tick();
    tick();
    chk("rst_settle_cnt_pre", SLIP_COUNT, 1);
    ARST = 1'b1;
    #1;
    chk("rst_settle_cnt",   SLIP_COUNT,   0);
    chk("rst_settle_slip",  RX_BIT_SLIP,  0);
    chk("rst_settle_data",  RX_DATA_OUT,  8'h00);
    chk("rst_settle_valid", RX_VALID_OUT, 0);
    chk("rst_settle_done",  TRAIN_DONE,   0);
    chk("rst_settle_fail",  TRAIN_FAIL,   0);
    tick();
    tick();
    ARST = 1'b0;
    slip_q.delete();
    repeat (12) tick();
    chk("post_rst_slips", slip_q.size(), 0);
    chk("post_rst_cnt", SLIP_COUNT, 0);
    chk("post_rst_done", TRAIN_DONE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
